// File: rtl/reg_status_ctrl_if.sv
// Dispatch/commit/lookup/RF-write bundle between the core and the register-status controller.
// The controller connects through the slave modport; the core side uses master.
interface reg_status_ctrl_if #(
   parameter int unsigned ROB_IDX_WIDTH = 3,
   parameter int unsigned XLEN          = 32
);
   logic                     rdy_in;
   logic                     flush_pipline;
   logic                     dispatch_valid;
   logic [4:0]               dispatch_rd;
   logic [ROB_IDX_WIDTH-1:0] dispatch_rob_id;
   logic                     commit_valid;
   logic [4:0]               commit_rd;
   logic [ROB_IDX_WIDTH-1:0] commit_rob_id;
   logic [XLEN-1:0]          commit_val;
   logic [4:0]               rs1_reg_id;
   logic [XLEN-1:0]          rs1_rf_val;
   logic                     rs1_busy;
   logic [ROB_IDX_WIDTH-1:0] rs1_rob_id;
   logic [XLEN-1:0]          rs1_val;
   logic [4:0]               rs2_reg_id;
   logic [XLEN-1:0]          rs2_rf_val;
   logic                     rs2_busy;
   logic [ROB_IDX_WIDTH-1:0] rs2_rob_id;
   logic [XLEN-1:0]          rs2_val;
   logic                     rf_wr_en;
   logic [4:0]               rf_wr_id;
   logic [XLEN-1:0]          rf_wr_val;
   logic [5:0]               busy_count;

   modport master (
      output rdy_in, flush_pipline,
      output dispatch_valid, dispatch_rd, dispatch_rob_id,
      output commit_valid, commit_rd, commit_rob_id, commit_val,
      output rs1_reg_id, rs1_rf_val, rs2_reg_id, rs2_rf_val,
      input  rs1_busy, rs1_rob_id, rs1_val,
      input  rs2_busy, rs2_rob_id, rs2_val,
      input  rf_wr_en, rf_wr_id, rf_wr_val, busy_count
   );

   modport slave (
      input  rdy_in, flush_pipline,
      input  dispatch_valid, dispatch_rd, dispatch_rob_id,
      input  commit_valid, commit_rd, commit_rob_id, commit_val,
      input  rs1_reg_id, rs1_rf_val, rs2_reg_id, rs2_rf_val,
      output rs1_busy, rs1_rob_id, rs1_val,
      output rs2_busy, rs2_rob_id, rs2_val,
      output rf_wr_en, rf_wr_id, rf_wr_val, busy_count
   );
endinterface

// File: rtl/reg_status_ctrl.sv
// Rename scoreboard: tracks which ROB entry will write each architectural register,
// forwards commits to the register file and bypasses same-cycle commit data to lookups.
module reg_status_ctrl #(
   parameter int unsigned ROB_IDX_WIDTH = 3,
   parameter int unsigned XLEN          = 32
) (
   input logic            clk_in,
   input logic            rst_n_in,
   reg_status_ctrl_if.slave bus
);
   localparam int unsigned NREG = 32;
   localparam int unsigned CNTW = 6;

   logic [NREG-1:0]                    busy_q, busy_d;
   logic [NREG-1:0][ROB_IDX_WIDTH-1:0] tag_q, tag_d;
   logic [CNTW-1:0]                    busy_count_q, busy_count_d;

   logic commit_eff_c;
   logic dispatch_eff_c;
   logic commit_clear_c;
   logic rs1_hit_c, rs2_hit_c;
   logic rs1_clear_c, rs2_clear_c;

   assign commit_eff_c   = bus.rdy_in && bus.commit_valid;
   assign dispatch_eff_c = bus.rdy_in && bus.dispatch_valid;
   // A commit only releases the register if it is still the latest producer.
   assign commit_clear_c = commit_eff_c && (bus.commit_rd != 5'd0)
                           && busy_q[bus.commit_rd]
                           && (tag_q[bus.commit_rd] == bus.commit_rob_id);

   assign bus.rf_wr_en  = commit_eff_c && (bus.commit_rd != 5'd0);
   assign bus.rf_wr_id  = bus.commit_rd;
   assign bus.rf_wr_val = bus.commit_val;

   // Next-state: flush beats everything; otherwise commit clears, then dispatch overrides.
   always_comb begin
      busy_d = busy_q;
      tag_d  = tag_q;
      if (bus.rdy_in) begin
         if (bus.flush_pipline) begin
            busy_d = '0;
         end else begin
            if (commit_clear_c) begin
               busy_d[bus.commit_rd] = 1'b0;
            end
            if (dispatch_eff_c && (bus.dispatch_rd != 5'd0)) begin
               busy_d[bus.dispatch_rd] = 1'b1;
               tag_d[bus.dispatch_rd]  = bus.dispatch_rob_id;
            end
         end
      end
      busy_d[0]    = 1'b0;
      busy_count_d = CNTW'($countones(busy_d));
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q       <= '0;
         tag_q        <= '0;
         busy_count_q <= '0;
      end else begin
         busy_q       <= busy_d;
         tag_q        <= tag_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign bus.busy_count = busy_count_q;

   // Lookups see pre-dispatch state; RF returns stale data on same-cycle writes, so bypass it.
   assign rs1_hit_c   = commit_eff_c && (bus.commit_rd == bus.rs1_reg_id) && (bus.rs1_reg_id != 5'd0);
   assign rs1_clear_c = rs1_hit_c && busy_q[bus.rs1_reg_id]
                        && (tag_q[bus.rs1_reg_id] == bus.commit_rob_id);
   assign bus.rs1_busy   = busy_q[bus.rs1_reg_id] && !rs1_clear_c && (bus.rs1_reg_id != 5'd0);
   assign bus.rs1_rob_id = (bus.rs1_reg_id == 5'd0) ? '0 : tag_q[bus.rs1_reg_id];
   assign bus.rs1_val    = (bus.rs1_reg_id == 5'd0) ? '0 :
                           rs1_hit_c ? bus.commit_val : bus.rs1_rf_val;

   assign rs2_hit_c   = commit_eff_c && (bus.commit_rd == bus.rs2_reg_id) && (bus.rs2_reg_id != 5'd0);
   assign rs2_clear_c = rs2_hit_c && busy_q[bus.rs2_reg_id]
                        && (tag_q[bus.rs2_reg_id] == bus.commit_rob_id);
   assign bus.rs2_busy   = busy_q[bus.rs2_reg_id] && !rs2_clear_c && (bus.rs2_reg_id != 5'd0);
   assign bus.rs2_rob_id = (bus.rs2_reg_id == 5'd0) ? '0 : tag_q[bus.rs2_reg_id];
   assign bus.rs2_val    = (bus.rs2_reg_id == 5'd0) ? '0 :
                           rs2_hit_c ? bus.commit_val : bus.rs2_rf_val;
endmodule

// File: doc/reg_status_ctrl.md
Name: reg_status_ctrl

Overview:
- Register-status (rename scoreboard) and write sequencer that sits in front of RegisterFile in the out-of-order core.
- Records, per architectural register, whether a ROB entry will write it and which entry.
- Forwards commit writes into the register file and bypasses same-cycle commit data to operand lookups, because the register file returns the old value on a same-cycle read/write.
- Clears all pending state on flush_pipline.

Parameters:
ROB_IDX_WIDTH, 3, width of ROB tag (ROB depth = 2**ROB_IDX_WIDTH)
XLEN, 32, data width

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset; asynchronous, active-low
rdy_in  in  1  ready; when low, all state is frozen
flush_pipline  in  1  clear all pending-write state
dispatch_valid  in  1  instruction with destination dispatched this cycle
dispatch_rd  in  5  destination register
dispatch_rob_id  in  ROB_IDX_WIDTH  ROB tag of dispatched instruction
commit_valid  in  1  ROB commits an instruction writing commit_rd
commit_rd  in  5  committed destination
commit_rob_id  in  ROB_IDX_WIDTH  ROB tag of committing entry
commit_val  in  XLEN  committed result
rs1_reg_id  in  5  source-1 lookup index (also drives RF rs1_reg_id)
rs1_rf_val  in  XLEN  RF read data for rs1
rs1_busy  out  1  rs1 has a pending producer
rs1_rob_id  out  ROB_IDX_WIDTH  producer tag for rs1
rs1_val  out  XLEN  rs1 value (bypassed)
rs2_reg_id, rs2_rf_val, rs2_busy, rs2_rob_id, rs2_val: same as rs1 for source 2
rf_wr_en  out  1  to RF is_writing_rd
rf_wr_id  out  5  to RF rd_reg_id
rf_wr_val  out  XLEN  to RF rd_val
busy_count  out  6  number of registers currently marked busy

Behaviour:
- State: busy[31:0], tag[31:0][ROB_IDX_WIDTH-1:0], busy_count register.
- Reset (rst_n_in low, asynchronous): all busy=0, all tag=0, busy_count=0. Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
- rdy_in low: no state update. rf_wr_en=0. Lookup outputs still reflect current state; bypass is disabled.
- Define "effective" as rdy_in=1 and the valid input asserted.
- RF write path (combinational):
  - rf_wr_en = effective commit and commit_rd!=0.
  - rf_wr_id = commit_rd; rf_wr_val = commit_val.
  - The RF then performs the write at the same posedge.
- Commit clear (posedge): if effective commit, busy[commit_rd]=1 and tag[commit_rd]==commit_rob_id, then busy[commit_rd] is set to 0. If the tag mismatches (a newer producer exists), busy is unchanged.
- Dispatch set (posedge): if effective dispatch, no flush, and dispatch_rd!=0, then busy[dispatch_rd]=1 and tag[dispatch_rd]=dispatch_rob_id.
- Same register dispatched and committed in one cycle: dispatch wins (busy=1, new tag).
- Flush (posedge, rdy_in=1): all busy cleared and busy_count=0. Dispatch in the same cycle is ignored. Commit in the same cycle still drives the RF write.
- x0: never busy. Lookups of x0 return busy=0, rob_id=0, val=0 regardless of inputs.
- Lookup (combinational, per source s):
  - clearing_s = effective commit and commit_rd==s and s!=0 and busy[s] and tag[s]==commit_rob_id.
  - rsN_busy = busy[s] and not clearing_s.
  - rsN_rob_id = tag[s].
  - rsN_val = commit_val if (rdy_in and commit_valid and commit_rd==s and s!=0); else rsN_rf_val.
  - A dispatch in the current cycle does NOT affect lookups in that cycle, so an instruction reading its own rd sees the prior producer.
- busy_count: next = popcount of next busy vector. It must equal popcount(busy) at every cycle boundary and is 0 after flush or reset. An incremental implementation is allowed if equivalent.

Test Plan:
1. Async reset mid-cycle with busy x5 -> busy_count=0 and rs1_busy=0 for x5 before the next posedge.
2. Dispatch rd=x3 tag=2; next cycle lookup rs1=x3 -> rs1_busy=1, rs1_rob_id=2, busy_count=1. Then commit rd=x3 tag=2 val=0xDEADBEEF with rs1=x3 in the same cycle -> rs1_busy=0, rs1_val=0xDEADBEEF, rf_wr_en=1, rf_wr_id=3. Next cycle busy_count=0.
3. Dispatch x7 tag=1, then x7 tag=4; commit x7 tag=1 -> RF written, x7 stays busy with tag=4, busy_count=1.
4. Same cycle: dispatch x9 tag=5, commit x9 (busy, tag=3), lookup rs2=x9 -> rs2_busy=0 that cycle. Next cycle x9 busy with tag=5.
5. Dispatch to x0 tag=6 and commit x0 val=0x1234 -> rf_wr_en=0, rs1=x0 gives busy=0 and val=0, busy_count unchanged.
6. With x1, x2, x4 busy: flush together with dispatch x8 and commit x1 val=0x55 -> rf_wr_en=1 that cycle. Next cycle all busy=0 (x8 not set), busy_count=0. Separately, rdy_in=0 with dispatch x10 -> no change, rf_wr_en=0.
